mux81_seq: RTL and testbench
============================

Name: mux81_seq

Overview:
Upstream sequencer for the 8:1 bit-select multiplexer. It accepts an 8-bit word on a start/ready handshake, holds the word on the mux data inputs, and steps the 3-bit select through all 8 positions. Each select value is held for DIV clocks, which serializes the word through the downstream mux. A one-cycle done pulse marks the end of each word.

Parameters:
DIV, 4, clock cycles each select value is held; legal range 1..256
MSB_FIRST, 0, 0 = select sequence 0→7; 1 = select sequence 7→0

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
data_in  input  8  word to serialize; sampled only on an accepted start
start  input  1  request; accepted when start=1 and ready=1 at a rising edge
ready  output  1  high only in IDLE
busy  output  1  high in SHIFT and DONE
i_out  output  8  latched word, drives the mux data inputs
s_out  output  3  select, drives the mux select
bit_strobe  output  1  high on the last cycle of each select period
bit_ref  output  1  i_out[s_out], a golden copy of the mux output for checking
done  output  1  one-cycle pulse after the 8th period

Behaviour:
- Reset (async assert, sync deassert by clk):
  - state=IDLE, i_out=0, s_out=0, prescaler=0, bit count=0.
  - ready=1, busy=0, bit_strobe=0, done=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - ready=1.
  - On start&ready at edge N: i_out←data_in; s_out←0 (MSB_FIRST=0) or 7 (MSB_FIRST=1); prescaler←0; count←0; next state SHIFT.
  - s_out is valid in the cycle after edge N.
- SHIFT:
  - Prescaler counts 0..DIV-1. bit_strobe=1 when prescaler==DIV-1.
  - On a strobe cycle: prescaler←0; s_out steps +1 (or -1 if MSB_FIRST); count←count+1.
  - On the strobe cycle with count==7: go to DONE. s_out is not stepped, so it holds its final value (7, or 0 if MSB_FIRST).
  - SHIFT lasts exactly 8*DIV cycles.
- DONE:
  - Lasts exactly one cycle. done=1, busy=1, ready=0. Next state IDLE.
  - i_out and s_out hold their values until the next accepted start.
- Latency: start accepted at edge N → done high during cycle N+8*DIV+1 → ready high in the following cycle. Minimum word-to-word spacing is 8*DIV+2 cycles.
- start while ready=0 (SHIFT or DONE) is ignored and not queued. data_in changes during SHIFT have no effect.
- DIV=1: bit_strobe is high for every SHIFT cycle; s_out changes every clock.
- Select wrap: s_out never wraps within a word. The counter is 3 bits, and the terminal step is suppressed as stated above.
- Width rules:
  - Prescaler width = max(1, clog2(DIV)).
  - Count is 3 bits; the terminal value is detected as 7, no 4th bit.
  - All arithmetic is unsigned.
- bit_ref is purely combinational from the registered i_out and s_out. It must equal the downstream mux output in every cycle.
- Reset asserted mid-word: all state clears immediately, no done pulse is produced, and ready=1 after deassertion.

Decomposition:
- Shared package/header holds:
  - state encodings: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2
  - SEL_W=3, DATA_W=8
- One natural sub-module: mux81_seq_presc, a parameterised DIV prescaler with clear input and terminal-count output. It is reused elsewhere for bit timing.
- The 8:1 mux itself stays outside this block. The testbench instantiates both and checks the mux output against bit_ref.

Test Plan:
1. Reset values: hold rst_n=0, pulse start → ready=1, busy=0, done=0, s_out=0, i_out=0 throughout.
2. LSB-first serialization: DIV=4, MSB_FIRST=0, data_in=8'hA5, start for 1 cycle → s_out = 0,1,…,7, each held 4 cycles. bit_ref and mux output = 1,0,1,0,0,1,0,1. Eight bit_strobe pulses, done exactly 33 cycles after the accepting edge.
3. MSB-first and DIV=1: DIV=1, MSB_FIRST=1, data_in=8'h3C → s_out = 7..0 on consecutive cycles. Serial stream = 0,0,1,1,1,1,0,0. done 9 cycles after acceptance, bit_strobe continuously high for 8 cycles.
4. Ignored start: start again with data_in=8'hFF mid-SHIFT of 8'h00 → no restart, i_out stays 8'h00, serial output all 0. A single done pulse; ready returns only afterwards.
5. Reset mid-word: assert rst_n=0 at the 3rd bit of 8'hF0 → immediate s_out=0, i_out=0, busy=0. No done pulse. A new start after deassertion serializes normally.
6. Back-to-back words: hold start=1 continuously with data_in=8'h81 → a new word is accepted every 8*DIV+2 cycles, and done pulses are spaced exactly 8*DIV+2 cycles apart.

Source files
------------

// File: rtl/mux81_seq_pkg.sv
// Shared definitions for the 8:1 mux select sequencer.
//   state_t : FSM encoding (IDLE, SHIFT, DONE)
//   SEL_W   : select width driving the downstream 8:1 mux
//   DATA_W  : width of the serialized word
package mux81_seq_pkg;

  localparam int SEL_W  = 3;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/mux81_seq_presc.sv
// Bit-period prescaler: counts 0..DIV-1 and wraps, flagging the last cycle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear to 0, wins over counting
//   tc         : terminal count, high while the count equals DIV-1
module mux81_seq_presc #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tc
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] count;

  assign tc = (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || tc) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mux81_seq.sv
// Upstream sequencer for an 8:1 bit-select mux. Latches a word on an
// accepted start, then walks the select over all 8 positions, holding each
// for DIV clocks, and pulses done for one cycle at the end of the word.
// Handshake: a word is taken at a rising edge where start=1 and ready=1;
// ready is high only in IDLE, and start while not ready is dropped.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   data_in    : word to serialize, sampled on the accepting edge only
//   start      : request
//   ready      : high in IDLE
//   busy       : high in SHIFT and DONE
//   i_out      : latched word, feeds the mux data inputs
//   s_out      : select, feeds the mux select
//   bit_strobe : last cycle of each select period
//   bit_ref    : i_out[s_out], reference copy of the mux output
//   done       : one-cycle pulse after the 8th period
module mux81_seq
  import mux81_seq_pkg::*;
#(
  parameter int DIV       = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              start,
  output logic              ready,
  output logic              busy,
  output logic [DATA_W-1:0] i_out,
  output logic [SEL_W-1:0]  s_out,
  output logic              bit_strobe,
  output logic              bit_ref,
  output logic              done
);

  localparam logic [SEL_W-1:0] SEL_FIRST = MSB_FIRST ? 3'd7 : 3'd0;

  state_t           state;
  logic [SEL_W-1:0] cnt;
  logic             tc;

  // Prescaler is held at 0 outside SHIFT so every word starts a fresh period.
  mux81_seq_presc #(.DIV(DIV)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state != SHIFT),
    .tc    (tc)
  );

  assign ready      = (state == IDLE);
  assign busy       = (state == SHIFT) || (state == DONE);
  assign done       = (state == DONE);
  assign bit_strobe = (state == SHIFT) && tc;
  assign bit_ref    = i_out[s_out];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      i_out <= '0;
      s_out <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            i_out <= data_in;
            s_out <= SEL_FIRST;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_strobe) begin
            cnt <= cnt + 3'd1;
            // Last period: leave s_out on its final position instead of wrapping.
            if (cnt == 3'd7) begin
              state <= DONE;
            end else if (MSB_FIRST) begin
              s_out <= s_out - 3'd1;
            end else begin
              s_out <= s_out + 3'd1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux81_seq.sv
// Bench for mux81_seq: two instances (DIV=4 LSB-first, DIV=1 MSB-first),
// each feeding a local 8:1 mux, driven with directed words.
module tb_mux81_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_a, start_b;
  logic [7:0] data_a, data_b;

  logic       a_ready, a_busy, a_strobe, a_ref, a_done;
  logic [7:0] a_i_out;
  logic [2:0] a_s_out;
  logic       b_ready, b_busy, b_strobe, b_ref, b_done;
  logic [7:0] b_i_out;
  logic [2:0] b_s_out;

  mux81_seq #(.DIV(4), .MSB_FIRST(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .data_in(data_a), .start(start_a),
    .ready(a_ready), .busy(a_busy), .i_out(a_i_out), .s_out(a_s_out),
    .bit_strobe(a_strobe), .bit_ref(a_ref), .done(a_done)
  );

  mux81_seq #(.DIV(1), .MSB_FIRST(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .data_in(data_b), .start(start_b),
    .ready(b_ready), .busy(b_busy), .i_out(b_i_out), .s_out(b_s_out),
    .bit_strobe(b_strobe), .bit_ref(b_ref), .done(b_done)
  );

  // Downstream 8:1 mux
  function automatic logic mux8(input logic [7:0] d, input logic [2:0] s);
    logic y;
    case (s)
      3'd0: y = d[0];
      3'd1: y = d[1];
      3'd2: y = d[2];
      3'd3: y = d[3];
      3'd4: y = d[4];
      3'd5: y = d[5];
      3'd6: y = d[6];
      default: y = d[7];
    endcase
    return y;
  endfunction

  logic mux_a, mux_b;
  assign mux_a = mux8(a_i_out, a_s_out);
  assign mux_b = mux8(b_i_out, b_s_out);

  // Selected view of one instance for the shared tasks
  logic       view_b;
  logic       v_ready, v_busy, v_strobe, v_ref, v_done, v_mux;
  logic [7:0] v_i_out;
  logic [2:0] v_s_out;
  assign v_ready  = view_b ? b_ready  : a_ready;
  assign v_busy   = view_b ? b_busy   : a_busy;
  assign v_strobe = view_b ? b_strobe : a_strobe;
  assign v_ref    = view_b ? b_ref    : a_ref;
  assign v_done   = view_b ? b_done   : a_done;
  assign v_mux    = view_b ? mux_b    : mux_a;
  assign v_i_out  = view_b ? b_i_out  : a_i_out;
  assign v_s_out  = view_b ? b_s_out  : a_s_out;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v, input logic [7:0] d);
    if (view_b) begin
      start_b = v;
      data_b  = d;
    end else begin
      start_a = v;
      data_a  = d;
    end
  endtask

  // Send one word and follow it cycle by cycle. Sampling happens on negedges;
  // e counts rising edges since the accepting edge. exp_lat is the cycle index
  // (accepting edge = cycle 0 boundary) in which done is high.
  task automatic serialize(input int div, input bit msb, input logic [7:0] data,
                           input logic [7:0] exp_stream, input int exp_lat,
                           input bit poke);
    int         strobes;
    logic [7:0] stream;
    logic [2:0] exp_s;
    strobes = 0;
    stream  = 8'h00;
    @(negedge clk);
    check("idle_ready", v_ready, 1'b1);
    set_start(1'b1, data);
    @(posedge clk);
    @(negedge clk);
    set_start(1'b0, 8'h00);
    for (int e = 0; e < exp_lat; e++) begin
      if (e > 0) @(negedge clk);
      if (poke && e == 3 * div)     set_start(1'b1, 8'hFF);
      if (poke && e == 3 * div + 1) set_start(1'b0, 8'h00);
      if (e < 8 * div) begin
        exp_s = msb ? 3'(7 - e / div) : 3'(e / div);
        check("s_out", v_s_out, exp_s);
        check("strobe", v_strobe, (e % div) == (div - 1));
        check("bit_ref", v_ref, data[exp_s]);
        check("mux_out", v_mux, data[exp_s]);
        check("shift_done", v_done, 1'b0);
        check("shift_ready", v_ready, 1'b0);
        check("shift_busy", v_busy, 1'b1);
        if (v_strobe) begin
          strobes++;
          stream = {stream[6:0], v_mux};
        end
      end else begin
        check("done_pulse", v_done, 1'b1);
        check("done_busy", v_busy, 1'b1);
        check("done_ready", v_ready, 1'b0);
        check("done_strobe", v_strobe, 1'b0);
        check("final_sel", v_s_out, msb ? 3'd0 : 3'd7);
        check("done_i_out", v_i_out, data);
      end
    end
    check("stream", stream, exp_stream);
    check("strobe_count", strobes, 8);
    @(negedge clk);
    check("post_ready", v_ready, 1'b1);
    check("post_done", v_done, 1'b0);
    check("post_busy", v_busy, 1'b0);
    check("hold_i_out", v_i_out, data);
    check("hold_sel", v_s_out, msb ? 3'd0 : 3'd7);
  endtask

  int dones[3];
  int n_done;

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    data_a  = 8'h00;
    data_b  = 8'h00;
    view_b  = 1'b0;

    // 1. Reset values, with start pulsed while in reset
    start_a = 1'b1; data_a = 8'hFF;
    start_b = 1'b1; data_b = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_a_ready", a_ready, 1'b1);
      check("rst_a_busy", a_busy, 1'b0);
      check("rst_a_done", a_done, 1'b0);
      check("rst_a_strobe", a_strobe, 1'b0);
      check("rst_a_s_out", a_s_out, 3'd0);
      check("rst_a_i_out", a_i_out, 8'h00);
      check("rst_b_ready", b_ready, 1'b1);
      check("rst_b_s_out", b_s_out, 3'd0);
      check("rst_b_i_out", b_i_out, 8'h00);
    end
    start_a = 1'b0; start_b = 1'b0;
    data_a  = 8'h00; data_b = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 2. LSB-first, DIV=4: A5 -> 1,0,1,0,0,1,0,1; done in cycle 33
    view_b = 1'b0;
    serialize(4, 1'b0, 8'hA5, 8'b1010_0101, 33, 1'b0);

    // 3. MSB-first, DIV=1: 3C -> 0,0,1,1,1,1,0,0; done in cycle 9
    view_b = 1'b1;
    serialize(1, 1'b1, 8'h3C, 8'b0011_1100, 9, 1'b0);

    // 4. Start with FF during SHIFT of 00 is dropped
    view_b = 1'b0;
    serialize(4, 1'b0, 8'h00, 8'h00, 33, 1'b1);

    // 5. Reset in the 3rd bit period of F0
    view_b = 1'b0;
    @(negedge clk);
    set_start(1'b1, 8'hF0);
    @(posedge clk);
    @(negedge clk);
    set_start(1'b0, 8'h00);
    repeat (8) @(negedge clk);
    check("mid_sel", a_s_out, 3'd2);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_s_out", a_s_out, 3'd0);
    check("mid_rst_i_out", a_i_out, 8'h00);
    check("mid_rst_busy", a_busy, 1'b0);
    check("mid_rst_ready", a_ready, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("mid_rst_done", a_done, 1'b0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("after_rst_done", a_done, 1'b0);
      check("after_rst_ready", a_ready, 1'b1);
    end
    // F0 LSB-first -> 0,0,0,0,1,1,1,1
    serialize(4, 1'b0, 8'hF0, 8'b0000_1111, 33, 1'b0);

    // 6. Start held high with 81: done pulses 8*4+2 = 34 cycles apart
    view_b = 1'b0;
    n_done = 0;
    @(negedge clk);
    set_start(1'b1, 8'h81);
    for (int c = 0; c < 200 && n_done < 3; c++) begin
      @(negedge clk);
      if (a_done) begin
        dones[n_done] = c;
        n_done++;
        check("b2b_i_out", a_i_out, 8'h81);
      end
    end
    check("b2b_done_count", n_done, 3);
    if (n_done == 3) begin
      check("b2b_gap1", dones[1] - dones[0], 34);
      check("b2b_gap2", dones[2] - dones[1], 34);
    end
    set_start(1'b0, 8'h00);
    repeat (40) @(negedge clk);
    check("end_ready", a_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
